// File: rtl/quotient_multiplier_if.sv
// Handshake bundle for quotient_multiplier: request side (Q, B) and response side (rounded dividend, residue, overflow).
interface quotient_multiplier_if #(
  parameter int ARG_BIT_WIDTH = 32,
  parameter int FRAC_BITS     = 32
);
  localparam int QW = ARG_BIT_WIDTH + FRAC_BITS;

  logic                     in_valid;
  logic                     in_ready;
  logic [QW-1:0]            Q;
  logic [ARG_BIT_WIDTH-1:0] B;
  logic                     out_valid;
  logic                     out_ready;
  logic [ARG_BIT_WIDTH-1:0] dividend_out;
  logic [FRAC_BITS-1:0]     frac_out;
  logic                     ovf;

  modport master (
    output in_valid, Q, B, out_ready,
    input  in_ready, out_valid, dividend_out, frac_out, ovf
  );

  modport slave (
    input  in_valid, Q, B, out_ready,
    output in_ready, out_valid, dividend_out, frac_out, ovf
  );
endinterface

// File: rtl/quotient_multiplier.sv
// Shift-add multiplier rebuilding dividend = Q x B; result ARG_BIT_WIDTH cycles after acceptance.
// One pair in flight: in_ready low until the result is taken; result held while out_ready is low.
module quotient_multiplier #(
  parameter int ARG_BIT_WIDTH = 32,
  parameter int FRAC_BITS     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  quotient_multiplier_if.slave bus
);
  localparam int PW = 2 * ARG_BIT_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(ARG_BIT_WIDTH + 1);
  localparam int IW = FRAC_BITS + ARG_BIT_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            mcand_q, mcand_d;
  logic [PW-1:0]            acc_q, acc_d;
  logic [ARG_BIT_WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]            count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = {{ARG_BIT_WIDTH{1'b0}}, bus.Q};
          mplier_d = bus.B;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Fixed iteration count keeps latency independent of B.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(ARG_BIT_WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [ARG_BIT_WIDTH-1:0] ipart;
  logic                     rnd;
  logic                     ovf_w;

  assign ipart = acc_q[IW-1:FRAC_BITS];
  assign rnd   = acc_q[FRAC_BITS-1];
  // Rounding up an all-ones integer part would wrap, so it counts as overflow too.
  assign ovf_w = (|acc_q[PW-1:IW]) || ((&ipart) && rnd);

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.ovf          = ovf_w;
  assign bus.dividend_out = ovf_w ? {ARG_BIT_WIDTH{1'b1}}
                                  : ipart + {{(ARG_BIT_WIDTH-1){1'b0}}, rnd};
  assign bus.frac_out     = acc_q[FRAC_BITS-1:0];
endmodule

// File: tb/tb_quotient_multiplier.sv
// Directed bench for quotient_multiplier: scoreboard of expected results, immediate-assertion checks.
module tb_quotient_multiplier;
  localparam int AW = 32;
  localparam int FW = 32;

  typedef struct {
    logic [AW-1:0] d;
    logic [FW-1:0] f;
    logic          o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  quotient_multiplier_if #(.ARG_BIT_WIDTH(AW), .FRAC_BITS(FW)) bus ();

  quotient_multiplier #(.ARG_BIT_WIDTH(AW), .FRAC_BITS(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [AW+FW-1:0] q, input logic [AW-1:0] b);
    logic [2*AW+FW-1:0] p;
    exp_t e;
    p   = {{AW{1'b0}}, q} * {{(AW+FW){1'b0}}, b};
    e.o = (|p[2*AW+FW-1:AW+FW]) || ((&p[AW+FW-1:FW]) && p[FW-1]);
    e.d = e.o ? {AW{1'b1}} : p[AW+FW-1:FW] + {{(AW-1){1'b0}}, p[FW-1]};
    e.f = p[FW-1:0];
    return e;
  endfunction

  // Drives one pair and checks latency and result. Called at posedge+1.
  // bp: cycles of held-off out_ready with noise on inputs; hold_rdy: out_ready high throughout.
  task automatic run(input string tag, input logic [AW+FW-1:0] q, input logic [AW-1:0] b,
                     input logic [AW-1:0] ed, input logic [FW-1:0] ef, input logic eo,
                     input int bp, input bit hold_rdy);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    e.d = ed; e.f = ef; e.o = eo;
    exp_q.push_back(e);
    bus.in_valid  = 1'b1;
    bus.Q         = q;
    bus.B         = b;
    bus.out_ready = hold_rdy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.Q        = {$urandom, $urandom};
    bus.B        = $urandom;
    check({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat = i;
      if (bus.out_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(AW));
    if (seen && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check({tag, "_dividend"}, 64'(bus.dividend_out), 64'(got.d));
      check({tag, "_frac"},     64'(bus.frac_out),     64'(got.f));
      check({tag, "_ovf"},      64'(bus.ovf),          64'(got.o));
      for (int i = 0; i < bp; i++) begin
        bus.in_valid = 1'b1;
        bus.Q        = {$urandom, $urandom};
        bus.B        = $urandom;
        @(posedge clk);
        #1;
        check({tag, "_bp_valid"},    64'(bus.out_valid),    64'd1);
        check({tag, "_bp_in_ready"}, 64'(bus.in_ready),     64'd0);
        check({tag, "_bp_dividend"}, 64'(bus.dividend_out), 64'(got.d));
        check({tag, "_bp_frac"},     64'(bus.frac_out),     64'(got.f));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, "_drain_valid"},    64'(bus.out_valid), 64'd0);
      check({tag, "_drain_in_ready"}, 64'(bus.in_ready),  64'd1);
      if (bp > 0) begin
        @(posedge clk);
        #1;
        check({tag, "_no_queued_capture"}, 64'(bus.in_ready), 64'd1);
      end
    end
  endtask

  initial begin
    exp_t m;
    logic [AW+FW-1:0] rq;
    logic [AW-1:0]    rb;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.Q         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready",  64'(bus.in_ready),     64'd1);
    check("rst_out_valid", 64'(bus.out_valid),    64'd0);
    check("rst_dividend",  64'(bus.dividend_out), 64'd0);
    check("rst_frac",      64'(bus.frac_out),     64'd0);
    check("rst_ovf",       64'(bus.ovf),          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("three_x7",   64'h00000003_00000000, 32'd7, 32'd21,        32'h0,        1'b0, 0, 1'b0);
    run("half_x3",    64'h00000002_80000000, 32'd3, 32'd8,         32'h80000000, 1'b0, 0, 1'b0);
    run("ovf_hi",     64'hFFFFFFFF_00000000, 32'd2, 32'hFFFFFFFF,  32'h0,        1'b1, 0, 1'b0);
    run("ovf_round",  64'hFFFFFFFF_80000000, 32'd1, 32'hFFFFFFFF,  32'h80000000, 1'b1, 0, 1'b0);
    run("b_zero",     64'h12345678_9ABCDEF0, 32'd0, 32'd0,         32'h0,        1'b0, 0, 1'b0);
    run("backpress",  64'h00000001_40000000, 32'd4, 32'd5,         32'h0,        1'b0, 10, 1'b0);
    run("ready_high", 64'h0000000A_00000001, 32'd3, 32'd30,        32'h3,        1'b0, 0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      rq = {$urandom, $urandom};
      rb = (k == 0) ? 32'hFFFFFFFF : $urandom_range(0, 65535);
      if (k == 3) rq[AW+FW-1:AW+FW-16] = '0;
      m = model(rq, rb);
      run($sformatf("rand%0d", k), rq, rb, m.d, m.f, m.o, 0, 1'b0);
    end

    // Abort a run mid-way with reset.
    exp_q.push_back(model(64'h00000001_00000000, 32'd9));
    bus.in_valid = 1'b1;
    bus.Q        = 64'h00000001_00000000;
    bus.B        = 32'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_out_valid", 64'(bus.out_valid),    64'd0);
    check("abort_in_ready",  64'(bus.in_ready),     64'd1);
    check("abort_dividend",  64'(bus.dividend_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("after_abort", 64'h00000001_00000000, 32'd5, 32'd5, 32'h0, 1'b0, 0, 1'b0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/quotient_multiplier.md
# quotient_multiplier

Sequential shift-add multiplier that performs the inverse of the divider datapath. It takes a fixed-point quotient (integer plus fraction bits) and the divisor, reconstructs the dividend as quotient × divisor, and returns the rounded integer result with its fractional residue. It sits downstream of the divider in the check/reconstruct path and connects through a valid/ready handshake on both sides.

## Interface
- ARG_BIT_WIDTH, 32, width of divisor input and of the integer part of the quotient and result
- FRAC_BITS, 32, fraction bits of the quotient; quotient width QW = ARG_BIT_WIDTH+FRAC_BITS
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  quotient/divisor pair valid
- in_ready  output  1  block can accept a pair
- Q  input  QW  unsigned fixed-point quotient, binary point above bit FRAC_BITS-1
- B  input  ARG_BIT_WIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- dividend_out  output  ARG_BIT_WIDTH  round-half-up integer of Q×B, saturated
- frac_out  output  FRAC_BITS  fractional bits of the exact product (before rounding)
- ovf  output  1  result exceeded ARG_BIT_WIDTH bits; dividend_out saturated

## Operation
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE.
- IDLE: in_ready=1. When in_valid is high at an edge, capture Q into mcand (PW = 2·ARG_BIT_WIDTH+FRAC_BITS bits, zero-extended), capture B into mplier, clear acc (PW bits), clear count, and go to BUSY.
- BUSY, once per edge:
  - if mplier[0]=1, acc += mcand;
  - mcand <<= 1; mplier >>= 1; count++.
  - After the edge where count reaches ARG_BIT_WIDTH-1, go to DONE. The number of iterations is fixed and there is no early exit.
- DONE: out_valid=1. Outputs are computed combinationally from the registered acc, or registered on entry; either way they hold stable for the whole of DONE.
  - ipart = acc[FRAC_BITS+ARG_BIT_WIDTH-1:FRAC_BITS]
  - rnd = acc[FRAC_BITS-1]
  - ovf = (acc[PW-1:FRAC_BITS+ARG_BIT_WIDTH] != 0) OR (ipart all ones AND rnd)
  - dividend_out = ovf ? all ones : ipart + rnd
  - frac_out = acc[FRAC_BITS-1:0]
- DONE → IDLE at the edge where out_ready=1.
- The product is exact to PW bits; no truncation occurs inside acc.
- B=0 is legal and yields dividend_out=0, frac_out=0, ovf=0.
- in_ready=0 in BUSY and DONE. in_valid in those states is ignored and not queued.

## Timing
- Reset (async assert, sync-safe deassert by the environment): state=IDLE, in_ready=1, out_valid=0, dividend_out=0, frac_out=0, ovf=0, acc=0, count=0.
- Acceptance edge E0 → BUSY for ARG_BIT_WIDTH edges → out_valid high after edge E0+ARG_BIT_WIDTH. That is 32 cycles at the default width.
- Result accepted at edge Ed (out_valid & out_ready) → in_ready high after Ed. The earliest next acceptance is Ed+1.
- Maximum throughput is one result per ARG_BIT_WIDTH+2 cycles.
- out_valid, once high, stays high with constant data until accepted. The consumer may hold out_ready low indefinitely.
- out_ready may be held high continuously; DONE then lasts exactly one cycle.
- Reset asserted in BUSY or DONE aborts immediately: out_valid drops asynchronously and the partial result is discarded.
- Inputs Q/B are sampled only at the acceptance edge. Later changes have no effect.

## Test plan
- Q=0x00000003_00000000 (3.0), B=7 → out_valid after E0+32: dividend_out=21, frac_out=0, ovf=0.
- Q=0x00000002_80000000 (2.5), B=3 → product 7.5: dividend_out=8, frac_out=0x80000000, ovf=0.
- Q=0xFFFFFFFF_00000000, B=2 → ovf=1, dividend_out=0xFFFFFFFF. Also Q=0xFFFFFFFF_80000000, B=1 → round carry: ovf=1, dividend_out=0xFFFFFFFF.
- Q=0x12345678_9ABCDEF0, B=0 → dividend_out=0, frac_out=0, ovf=0, latency still 32.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises, toggling Q/B/in_valid → outputs unchanged, in_ready=0, no second capture. Raise out_ready → in_ready=1 on the next cycle.
- Assert rst_n=0 at count=15 of a run → out_valid=0 and in_ready=1 immediately. A new pair (Q=1.0, B=5) then returns dividend_out=5 with full 32-cycle latency.
